// File: rtl/trap_pkg.sv
// Shared constants for the trap sequencer: CSR addresses, cause codes,
// mstatus bit positions and the sequencer state encoding.
package trap_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [31:0] CAUSE_ILLEGAL  = 32'd2;
    localparam logic [31:0] CAUSE_LFAULT   = 32'd5;
    localparam logic [31:0] CAUSE_SFAULT   = 32'd7;
    localparam logic [31:0] CAUSE_ECALL    = 32'd11;
    localparam logic [31:0] CAUSE_MEXT_IRQ = 32'h8000_000B;
    localparam logic [31:0] IRQ_CODE_MEXT  = 32'd11;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_W_EPC   = 3'd1,
        ST_W_CAUSE = 3'd2,
        ST_W_TVAL  = 3'd3,
        ST_JUMP    = 3'd4,
        ST_RET     = 3'd5
    } trap_state_e;

endpackage

// File: rtl/trap_cause_encoder.sv
// Priority encoder turning MEM-stage exception/interrupt/mret flags into
// a single trap decision with its cause and tval.
module trap_cause_encoder
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            mem_valid,
    input  logic            exc_illegal,
    input  logic            exc_ecall,
    input  logic            exc_lfault,
    input  logic            exc_sfault,
    input  logic            mem_mret,
    input  logic            ext_irq,
    input  logic            irq_enable,
    input  logic [31:0]     mem_inst,
    input  logic [XLEN-1:0] mem_addr,
    output logic            take,
    output logic            is_mret,
    output logic [XLEN-1:0] cause,
    output logic [XLEN-1:0] tval
);

    always_comb begin
        take    = 1'b0;
        is_mret = 1'b0;
        cause   = '0;
        tval    = '0;
        if (mem_valid) begin
            if (exc_illegal) begin
                take  = 1'b1;
                cause = XLEN'(CAUSE_ILLEGAL);
                tval  = XLEN'(mem_inst);
            end else if (exc_ecall) begin
                take  = 1'b1;
                cause = XLEN'(CAUSE_ECALL);
            end else if (exc_lfault) begin
                take  = 1'b1;
                cause = XLEN'(CAUSE_LFAULT);
                tval  = mem_addr;
            end else if (exc_sfault) begin
                take  = 1'b1;
                cause = XLEN'(CAUSE_SFAULT);
                tval  = mem_addr;
            end else if (ext_irq && irq_enable) begin
                // Interrupt bit is the MSB regardless of XLEN
                take  = 1'b1;
                cause = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(IRQ_CODE_MEXT);
            end else if (mem_mret) begin
                is_mret = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trap_controller.sv
// Trap sequencer: accepts a trap or mret in IDLE, serializes the mepc/mcause/
// mtval writes to CSR write port 2, then redirects the PC.
module trap_controller
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    input  logic [XLEN-1:0] mem_pc,
    input  logic [31:0]     mem_inst,
    input  logic [XLEN-1:0] mem_addr,
    input  logic            exc_illegal,
    input  logic            exc_ecall,
    input  logic            exc_lfault,
    input  logic            exc_sfault,
    input  logic            mem_mret,
    input  logic            ext_irq,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic            csr_w2,
    output logic [11:0]     waddr2,
    output logic [XLEN-1:0] wdata2,
    output logic [1:0]      csr_wsc_mode2,
    output logic            trap_begin,
    output logic            trap_end,
    output logic            flush,
    output logic            stall,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);

    trap_state_e     state, state_next;
    logic            take, is_mret;
    logic [XLEN-1:0] cause, tval;
    logic [XLEN-1:0] pc_q, cause_q, tval_q;
    logic            unused_bits;

    trap_cause_encoder #(.XLEN(XLEN)) u_enc (
        .mem_valid   (mem_valid),
        .exc_illegal (exc_illegal),
        .exc_ecall   (exc_ecall),
        .exc_lfault  (exc_lfault),
        .exc_sfault  (exc_sfault),
        .mem_mret    (mem_mret),
        .ext_irq     (ext_irq),
        .irq_enable  (mstatus[MSTATUS_MIE]),
        .mem_inst    (mem_inst),
        .mem_addr    (mem_addr),
        .take        (take),
        .is_mret     (is_mret),
        .cause       (cause),
        .tval        (tval)
    );

    assign unused_bits = ^{mstatus[XLEN-1:MSTATUS_MIE+1], mstatus[MSTATUS_MIE-1:0],
                           mtvec[1:0], mem_pc[1:0], pc_q[1:0]};

    assign csr_wsc_mode2 = 2'b01;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            pc_q    <= '0;
            cause_q <= '0;
            tval_q  <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && take) begin
                pc_q    <= {mem_pc[XLEN-1:2], 2'b00};
                cause_q <= cause;
                tval_q  <= tval;
            end
        end
    end

    always_comb begin
        state_next  = state;
        csr_w2      = 1'b0;
        waddr2      = '0;
        wdata2      = '0;
        trap_begin  = 1'b0;
        trap_end    = 1'b0;
        flush       = 1'b0;
        stall       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        unique case (state)
            ST_IDLE: begin
                stall = 1'b0;
                if (take) begin
                    trap_begin = 1'b1;
                    flush      = 1'b1;
                    stall      = 1'b1;
                    state_next = ST_W_EPC;
                end else if (is_mret) begin
                    trap_end   = 1'b1;
                    flush      = 1'b1;
                    stall      = 1'b1;
                    state_next = ST_RET;
                end
            end
            ST_W_EPC: begin
                csr_w2     = 1'b1;
                waddr2     = CSR_MEPC;
                wdata2     = pc_q;
                state_next = ST_W_CAUSE;
            end
            ST_W_CAUSE: begin
                csr_w2     = 1'b1;
                waddr2     = CSR_MCAUSE;
                wdata2     = cause_q;
                state_next = ST_W_TVAL;
            end
            ST_W_TVAL: begin
                csr_w2     = 1'b1;
                waddr2     = CSR_MTVAL;
                wdata2     = tval_q;
                state_next = ST_JUMP;
            end
            ST_JUMP: begin
                // Direct mode only: mode bits of mtvec are dropped
                redirect    = 1'b1;
                redirect_pc = {mtvec[XLEN-1:2], 2'b00};
                state_next  = ST_IDLE;
            end
            ST_RET: begin
                redirect    = 1'b1;
                redirect_pc = mepc;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: doc/trap_controller.md
# trap_controller

- Sequential trap sequencer that sits directly upstream of the CSR register file.
- Takes exception/interrupt/`mret` events from the MEM stage and turns them into three things:
  - the CSR file's trap strobes (`trap_begin`, `trap_end`);
  - serialized writes on the CSR file's second write port (mepc, mcause, mtval);
  - a PC redirect plus pipeline flush/stall.
- Consumes the CSR file's `mstatus`, `mtvec` and `mepc` outputs.

## Interface
Parameters:
- `XLEN`, default 32: data/PC width.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_valid`  in  1  MEM-stage instruction is valid.
- `mem_pc`  in  XLEN  PC of MEM-stage instruction.
- `mem_inst`  in  32  raw instruction word, used as mtval for illegal instruction.
- `mem_addr`  in  XLEN  data address, used as mtval for access faults.
- `exc_illegal`, `exc_ecall`, `exc_lfault`, `exc_sfault`  in  1 each  synchronous exception flags.
- `mem_mret`  in  1  MEM-stage instruction is `mret`.
- `ext_irq`  in  1  level-sensitive external interrupt request.
- `mstatus`, `mtvec`, `mepc`  in  XLEN  from the CSR file.
- `csr_w2`  out  1  CSR write-port-2 enable.
- `waddr2`  out  12  CSR write address.
- `wdata2`  out  XLEN  CSR write data.
- `csr_wsc_mode2`  out  2  write mode; always 2'b01 (plain write).
- `trap_begin`, `trap_end`  out  1  one-cycle strobes to the CSR file.
- `flush`  out  1  kill IF..MEM instructions.
- `stall`  out  1  freeze pipeline PC/registers.
- `redirect`  out  1  load `redirect_pc` into the PC.
- `redirect_pc`  out  XLEN  redirect target.

## Operation
States: IDLE, W_EPC, W_CAUSE, W_TVAL, JUMP, RET.

**Event priority in IDLE** (evaluated only when `mem_valid`):
1. illegal instruction: cause 2, tval = `mem_inst`.
2. ecall: cause 11, tval = 0.
3. load fault: cause 5, tval = `mem_addr`.
4. store fault: cause 7, tval = `mem_addr`.
5. interrupt: taken only if `ext_irq && mstatus[3]`; cause 32'h8000_000B, tval = 0.
6. mret: only if no higher-priority event is present.

**Trap accept** (IDLE, any of priorities 1-5 fires):
- Same cycle: `trap_begin`=1 and `flush`=1.
- Latch `mem_pc`, the cause and the tval.
- Next state W_EPC.

**Write sequence:**
- W_EPC: `csr_w2`=1, `waddr2`=12'h341, `wdata2`= latched PC with bits [1:0] cleared.
- W_CAUSE: `csr_w2`=1, `waddr2`=12'h342, `wdata2`= latched cause.
- W_TVAL: `csr_w2`=1, `waddr2`=12'h343, `wdata2`= latched tval.
- JUMP: `redirect`=1, `redirect_pc`= `mtvec` & ~3 (direct mode only), then IDLE.

**mret accept** (IDLE):
- Same cycle: `trap_end`=1 and `flush`=1; next state RET.
- RET: `redirect`=1, `redirect_pc`= `mepc`, then IDLE.

**Rules:**
- `stall`=1 in every state except IDLE, and in the IDLE accept cycle.
- Inputs are ignored outside IDLE; the pipeline is stalled, so no events are lost.
- A level `ext_irq` that loses to an exception stays pending and is re-evaluated once back in IDLE.
- The interrupt is not taken in the cycle after JUMP unless `mstatus[3]` is 1 again.
- `wdata2`/`waddr2` are 0 whenever `csr_w2`=0.
- `redirect_pc` is 0 whenever `redirect`=0.

## Timing
- Reset: state = IDLE; all outputs 0 except `csr_wsc_mode2`=2'b01; latches cleared.
- Reset mid-sequence: abandons the sequence and returns to IDLE next cycle; no further CSR writes.
- Trap latency: accept cycle T, then mepc/mcause/mtval writes at T+1/T+2/T+3, redirect at T+4, IDLE at T+5. Five cycles of stall in total.
- mret latency: accept cycle T, redirect at T+1, IDLE at T+2.
- `mtvec` is sampled in the JUMP cycle; `mepc` is sampled in the RET cycle. These are the CSR-file values as of that cycle, so the mepc written at T+1 is visible to a later mret.
- All outputs are registered-state decodes. The exceptions are `trap_begin`, `trap_end`, `flush` and `stall` in the accept cycle, which are combinational from IDLE and the inputs.
- Simultaneous `mem_mret` plus exception: the exception wins, no `trap_end`, and mret is not replayed.

## Structure
- Shared package `trap_pkg` holds:
  - CSR address constants: MSTATUS 12'h300, MTVEC 12'h305, MEPC 12'h341, MCAUSE 12'h342, MTVAL 12'h343.
  - Cause codes.
  - State encoding (3-bit).
  - MSTATUS_MIE=3, MSTATUS_MPIE=7.
- Sub-module `trap_cause_encoder`: combinational priority encoder producing {take, is_mret, cause, tval} from the flags.
- The FSM and latches live in `trap_controller`.

## Test plan
- **Illegal instruction:** `exc_illegal` with `mem_pc`=0x100, `mem_inst`=0xFFFFFFFF, `mtvec`=0x200 -> `trap_begin` at T; writes 0x341←0x100, 0x342←2, 0x343←0xFFFFFFFF at T+1..T+3; `redirect_pc`=0x200 at T+4.
- **Priority:** `exc_ecall` and `exc_lfault` together with `mem_addr`=0x44 -> mcause 11, mtval 0.
- **Interrupt masking:** `ext_irq` with `mstatus`=0x80 -> no trap. With `mstatus`=0x88 and `mem_pc`=0x20 -> mcause 0x8000000B, mepc 0x20.
- **mret:** `mem_mret` with `mepc`=0x104 -> `trap_end` at T, `redirect_pc`=0x104 at T+1, no `csr_w2` pulses.
- **Exception beats irq/mret:** exception + `ext_irq` + `mem_mret` in the same cycle -> exception cause only, no `trap_end`; after IDLE with MIE=1, irq is taken next.
- **Reset mid-sequence:** `rst` in W_CAUSE -> next cycle all outputs 0, state IDLE, no mtval write.
